ppu_vram_arbiter: RTL and testbench
===================================

// Module: ppu_vram_arbiter
// PURPOSE
//  Sequences and shares the PPU external VRAM bus (ALE/APPU/PPUDO/PPUDI) between two requesters.
//  Requesters: the render fetch engine (REN_*) and the CPU $2007 data port (CPU_*).
//  Every access is a 2-cycle bus transaction: address phase (ALE high), then data phase.
//  Sits between ppu_core's register/fetch logic and the VRAM/CHR bus pins.
// PARAMETERS
//  STARVE_MAX  8  consecutive render grants with CPU_REQ pending before the CPU is forced a slot (PPU_ARB_STARVE_EN only)
// PORTS
//  PPU_SLOW_CLOCK  in   1   sole clock; all state updates on the rising edge
//  RST             in   1   reset, asynchronous, active-high
//  RENDERING       in   1   1 = rendering active (render priority), 0 = blank (CPU priority)
//  REN_REQ         in   1   render fetch request; level, held until REN_GNT
//  REN_ADDR        in   14  render fetch address; read-only requester
//  REN_GNT         out  1   1-cycle pulse: render request accepted, REN_ADDR captured
//  REN_VALID       out  1   1-cycle pulse: REN_DATA holds fetched byte
//  REN_DATA        out  8   fetched byte; holds value until next render read
//  CPU_REQ         in   1   CPU port request; level, held until CPU_GNT
//  CPU_WE          in   1   1 = write, 0 = read; sampled with CPU_ADDR
//  CPU_ADDR        in   14  CPU access address
//  CPU_WDATA       in   8   CPU write data; captured at grant
//  CPU_GNT         out  1   1-cycle pulse: CPU request accepted, ADDR/WE/WDATA captured
//  CPU_VALID       out  1   1-cycle pulse: CPU access complete (read data valid when read)
//  CPU_RDATA       out  8   CPU read byte; unchanged by writes
//  ALE             out  1   address latch enable, high during address phase
//  APPU            out  14  bus address, driven through address and data phases
//  PPUDO           out  8   bus write data, valid during data phase of a write
//  PPU_WR          out  1   write strobe, high only during data phase of a CPU write
//  PPUDI           in   8   bus read data, sampled at the edge ending the data phase
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, starve counter 0. Async assertion mid-transaction
//   abandons it: no VALID is issued and the requester must re-request.
//  FSM states: IDLE, ADDR, DATA. All outputs registered.
//   IDLE: if any REQ then ADDR (grant per arbitration), else IDLE.
//   ADDR: ALE=1, APPU=captured addr, the winner's GNT=1 for this cycle only; next state DATA.
//   DATA: ALE=0, APPU held; for writes PPU_WR=1 and PPUDO=wdata. At the ending edge:
//    read: PPUDI -> REN_DATA/CPU_RDATA; the owner's VALID=1 in the following cycle.
//    Arbitrate again at the same edge: pending REQ -> ADDR (back-to-back), else IDLE.
//  Timing: REQ sampled at edge E -> GNT cycle E+1 -> VALID cycle E+3.
//   Peak throughput: one access per 2 cycles.
//  Arbitration at IDLE or end-of-DATA edges only:
//   RENDERING=1: render wins a tie. RENDERING=0: CPU wins a tie.
//   A lone requester always wins.
//  A REQ still high at the edge ending DATA counts as a new request.
//   Requesters drop REQ in their GNT cycle for a single access.
//  RENDERING changes mid-transaction: no effect until the next arbitration edge.
//  No queueing: at most one transaction in flight. Addresses are 14-bit, no wrap or mirroring here.
// CONFIGURATION
//  PPU_ARB_STARVE_EN defined:
//   The starve counter increments on each render grant made while CPU_REQ=1.
//   When counter==STARVE_MAX, the next arbitration grants the CPU regardless of RENDERING.
//   The counter clears on CPU grant or whenever CPU_REQ=0.
//  PPU_ARB_STARVE_EN undefined: strict priority; the CPU can be starved indefinitely
//   while RENDERING=1 and REN_REQ=1. No counter logic exists.
// TESTING
//  1. Reset, RENDERING=0, CPU read 0x2005; PPUDI=0xA5 in DATA
//     -> CPU_GNT @E+1, ALE=1 @E+1, CPU_VALID @E+3, CPU_RDATA=0xA5.
//  2. CPU write 0x3F00 data 0x27
//     -> DATA cycle has APPU=0x3F00, PPUDO=0x27, PPU_WR=1; CPU_VALID pulses; CPU_RDATA unchanged.
//  3. RENDERING=1, REN_REQ and CPU_REQ rise together
//     -> REN_GNT first; CPU_GNT 2 cycles later (REN drops REQ); with RENDERING=0 the order reverses.
//  4. REN_REQ held high 6 transactions, addresses 0x0000..0x0005
//     -> ALE pulses every 2 cycles, 6 REN_VALIDs, each REN_DATA matches that PPUDI.
//  5. (STARVE_EN, STARVE_MAX=8) RENDERING=1, REN_REQ and CPU_REQ both held
//     -> 8 REN_GNTs, then 1 CPU_GNT, then render resumes. Without the macro: no CPU_GNT.
//  6. RST asserted during DATA of a CPU read
//     -> outputs 0 immediately (async), no CPU_VALID; a fresh request after release completes normally.

Source files
------------

// File: rtl/ppu_vram_arbiter.sv
// rtl/ppu_vram_arbiter.sv - PPU VRAM bus sequencer sharing ALE/APPU/PPUDO/PPUDI between render and CPU
// Optional CPU anti-starvation slot: define PPU_ARB_STARVE_EN.
module ppu_vram_arbiter
`ifdef PPU_ARB_STARVE_EN
#(
  parameter int STARVE_MAX = 8
)
`endif
(
  input  logic        PPU_SLOW_CLOCK,
  input  logic        RST,
  input  logic        RENDERING,
  input  logic        REN_REQ,
  input  logic [13:0] REN_ADDR,
  output logic        REN_GNT,
  output logic        REN_VALID,
  output logic [7:0]  REN_DATA,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [13:0] CPU_ADDR,
  input  logic [7:0]  CPU_WDATA,
  output logic        CPU_GNT,
  output logic        CPU_VALID,
  output logic [7:0]  CPU_RDATA,
  output logic        ALE,
  output logic [13:0] APPU,
  output logic [7:0]  PPUDO,
  output logic        PPU_WR,
  input  logic [7:0]  PPUDI
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, state_n;
  logic        own_cpu, own_cpu_n;
  logic        cur_we, cur_we_n;
  logic [7:0]  cur_wdata, cur_wdata_n;
  logic        ale_n, ren_gnt_n, cpu_gnt_n, ren_valid_n, cpu_valid_n, ppu_wr_n;
  logic [13:0] appu_n;
  logic [7:0]  ppudo_n, ren_data_n, cpu_rdata_n;
  logic        arb_edge, cpu_win, ren_win, starve_hit;

`ifdef PPU_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CW'(STARVE_MAX));

  // Counts render grants taken while the CPU waits; any CPU idle cycle forgives the debt.
  always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
    if (RST)                         starve_cnt <= '0;
    else if (!CPU_REQ || cpu_win)    starve_cnt <= '0;
    else if (ren_win && !starve_hit) starve_cnt <= starve_cnt + CW'(1);
  end
`else
  assign starve_hit = 1'b0;
`endif

  // New requests are only looked at when the bus is idle or a data phase is ending.
  assign arb_edge = (state == IDLE) || (state == DATA);
  assign cpu_win  = arb_edge && CPU_REQ && (!REN_REQ || !RENDERING || starve_hit);
  assign ren_win  = arb_edge && REN_REQ && !cpu_win;

  always_comb begin
    state_n     = state;
    own_cpu_n   = own_cpu;
    cur_we_n    = cur_we;
    cur_wdata_n = cur_wdata;
    ale_n       = 1'b0;
    ren_gnt_n   = 1'b0;
    cpu_gnt_n   = 1'b0;
    ren_valid_n = 1'b0;
    cpu_valid_n = 1'b0;
    ppu_wr_n    = 1'b0;
    ppudo_n     = 8'h00;
    appu_n      = APPU;
    ren_data_n  = REN_DATA;
    cpu_rdata_n = CPU_RDATA;

    case (state)
      ADDR: begin
        state_n  = DATA;
        ppu_wr_n = own_cpu && cur_we;
        ppudo_n  = (own_cpu && cur_we) ? cur_wdata : 8'h00;
      end
      DATA: begin
        state_n = IDLE;
        if (own_cpu) begin
          cpu_valid_n = 1'b1;
          if (!cur_we) cpu_rdata_n = PPUDI;
        end else begin
          ren_valid_n = 1'b1;
          ren_data_n  = PPUDI;
        end
      end
      default: ;
    endcase

    // A grant overrides the IDLE fall-back so back-to-back accesses need no idle cycle.
    if (cpu_win) begin
      state_n     = ADDR;
      ale_n       = 1'b1;
      cpu_gnt_n   = 1'b1;
      appu_n      = CPU_ADDR;
      own_cpu_n   = 1'b1;
      cur_we_n    = CPU_WE;
      cur_wdata_n = CPU_WDATA;
    end else if (ren_win) begin
      state_n     = ADDR;
      ale_n       = 1'b1;
      ren_gnt_n   = 1'b1;
      appu_n      = REN_ADDR;
      own_cpu_n   = 1'b0;
      cur_we_n    = 1'b0;
      cur_wdata_n = 8'h00;
    end
  end

  always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      own_cpu   <= 1'b0;
      cur_we    <= 1'b0;
      cur_wdata <= 8'h00;
      ALE       <= 1'b0;
      REN_GNT   <= 1'b0;
      CPU_GNT   <= 1'b0;
      REN_VALID <= 1'b0;
      CPU_VALID <= 1'b0;
      PPU_WR    <= 1'b0;
      PPUDO     <= 8'h00;
      APPU      <= 14'h0000;
      REN_DATA  <= 8'h00;
      CPU_RDATA <= 8'h00;
    end else begin
      state     <= state_n;
      own_cpu   <= own_cpu_n;
      cur_we    <= cur_we_n;
      cur_wdata <= cur_wdata_n;
      ALE       <= ale_n;
      REN_GNT   <= ren_gnt_n;
      CPU_GNT   <= cpu_gnt_n;
      REN_VALID <= ren_valid_n;
      CPU_VALID <= cpu_valid_n;
      PPU_WR    <= ppu_wr_n;
      PPUDO     <= ppudo_n;
      APPU      <= appu_n;
      REN_DATA  <= ren_data_n;
      CPU_RDATA <= cpu_rdata_n;
    end
  end
endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb/tb_ppu_vram_arbiter.sv - randomized self-checking bench for ppu_vram_arbiter
// Transaction-level reference model; honours PPU_ARB_STARVE_EN like the design.
module tb_ppu_vram_arbiter;
`ifdef PPU_ARB_STARVE_EN
  localparam int STARVE_MAX = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rendering = 1'b0, ren_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [13:0] ren_addr = 14'h0, cpu_addr = 14'h0;
  logic [7:0]  cpu_wdata = 8'h0, ppudi = 8'h0;
  logic        ren_gnt, ren_valid, cpu_gnt, cpu_valid, ale, ppu_wr;
  logic [7:0]  ren_data, cpu_rdata, ppudo;
  logic [13:0] appu;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ppu_vram_arbiter dut (
    .PPU_SLOW_CLOCK(clk), .RST(rst), .RENDERING(rendering),
    .REN_REQ(ren_req), .REN_ADDR(ren_addr), .REN_GNT(ren_gnt), .REN_VALID(ren_valid), .REN_DATA(ren_data),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_GNT(cpu_gnt), .CPU_VALID(cpu_valid), .CPU_RDATA(cpu_rdata),
    .ALE(ale), .APPU(appu), .PPUDO(ppudo), .PPU_WR(ppu_wr), .PPUDI(ppudi)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs seen at each edge, plus the transaction in its address / data phase.
  logic        s_rst, s_rend, s_rreq, s_creq, s_cwe;
  logic [13:0] s_raddr, s_caddr;
  logic [7:0]  s_cwd, s_di;
  logic        a_v = 1'b0, a_cpu = 1'b0, a_we = 1'b0;
  logic [13:0] a_addr = 14'h0;
  logic [7:0]  a_wd = 8'h0;
  logic        d_v = 1'b0, d_cpu = 1'b0, d_we = 1'b0;
  logic [13:0] d_addr = 14'h0;
  logic [7:0]  d_wd = 8'h0;
  logic [7:0]  m_rdata = 8'h0, m_cdata = 8'h0;
  logic        e_cpu, e_ren, e_rv, e_cv, hit;
  int          n_cpu_dut = 0, n_cpu_mdl = 0;
`ifdef PPU_ARB_STARVE_EN
  int          m_starve = 0;
`endif

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst; s_rend = rendering; s_rreq = ren_req; s_creq = cpu_req; s_cwe = cpu_we;
      s_raddr = ren_addr; s_caddr = cpu_addr; s_cwd = cpu_wdata; s_di = ppudi;
      @(negedge clk);
      if (rst || s_rst) begin
        check_eq("rst_ctl", {26'd0, ren_gnt, ren_valid, cpu_gnt, cpu_valid, ale, ppu_wr}, 32'd0);
        check_eq("rst_data", {8'd0, ren_data, cpu_rdata, ppudo}, 32'd0);
        check_eq("rst_appu", {18'd0, appu}, 32'd0);
        a_v = 1'b0; d_v = 1'b0; m_rdata = 8'h0; m_cdata = 8'h0;
`ifdef PPU_ARB_STARVE_EN
        m_starve = 0;
`endif
      end else begin
        hit = 1'b0;
`ifdef PPU_ARB_STARVE_EN
        hit = (m_starve == STARVE_MAX);
`endif
        // No arbitration on the edge that closes an address phase.
        e_cpu = !a_v && s_creq && (!s_rreq || !s_rend || hit);
        e_ren = !a_v && s_rreq && !e_cpu;
`ifdef PPU_ARB_STARVE_EN
        if (!s_creq || e_cpu) m_starve = 0;
        else if (e_ren) m_starve++;
`endif
        e_rv = d_v && !d_cpu;
        e_cv = d_v && d_cpu;
        if (d_v && !d_we) begin
          if (d_cpu) m_cdata = s_di;
          else       m_rdata = s_di;
        end
        d_v = a_v; d_cpu = a_cpu; d_we = a_we; d_addr = a_addr; d_wd = a_wd;
        a_v = e_cpu || e_ren; a_cpu = e_cpu; a_we = e_cpu && s_cwe;
        a_addr = e_cpu ? s_caddr : s_raddr; a_wd = s_cwd;

        check_eq("ren_gnt", {31'd0, ren_gnt}, {31'd0, e_ren});
        check_eq("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, e_cpu});
        check_eq("ale", {31'd0, ale}, {31'd0, a_v});
        check_eq("ren_valid", {31'd0, ren_valid}, {31'd0, e_rv});
        check_eq("cpu_valid", {31'd0, cpu_valid}, {31'd0, e_cv});
        check_eq("ren_data", {24'd0, ren_data}, {24'd0, m_rdata});
        check_eq("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, m_cdata});
        check_eq("ppu_wr", {31'd0, ppu_wr}, {31'd0, d_v && d_we});
        if (a_v) check_eq("appu_addr_phase", {18'd0, appu}, {18'd0, a_addr});
        if (d_v) check_eq("appu_data_phase", {18'd0, appu}, {18'd0, d_addr});
        if (d_v && d_we) check_eq("ppudo", {24'd0, ppudo}, {24'd0, d_wd});
        if (cpu_gnt) n_cpu_dut++;
        if (e_cpu)   n_cpu_mdl++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of requester behaviour; hold keeps both sides requesting with RENDERING=1.
  task automatic drive_cycle(input bit hold);
    logic gr, gc;
    @(negedge clk);
    gr = ren_gnt;
    gc = cpu_gnt;
    @(posedge clk);
    #1;
    ppudi = 8'($urandom);
    if (hold) rendering = 1'b1;
    else if ($urandom_range(0, 15) == 0) rendering = ~rendering;
    if (ren_req && gr) begin
      ren_req  = hold || ($urandom_range(0, 3) == 0);
      ren_addr = ren_addr + 14'd1;
    end else if (!ren_req && (hold || $urandom_range(0, 2) == 0)) begin
      ren_req  = 1'b1;
      ren_addr = 14'($urandom);
    end
    if (cpu_req && gc) begin
      cpu_req   = hold || ($urandom_range(0, 3) == 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 14'($urandom);
      cpu_wdata = 8'($urandom);
    end else if (!cpu_req && (hold || $urandom_range(0, 2) == 0)) begin
      cpu_req   = 1'b1;
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 14'($urandom);
      cpu_wdata = 8'($urandom);
    end
  endtask

  initial begin
    int c0_dut, c0_mdl;
    bit got;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (3000) drive_cycle(1'b0);

    repeat (4) drive_cycle(1'b1);
    c0_dut = n_cpu_dut;
    c0_mdl = n_cpu_mdl;
    repeat (120) drive_cycle(1'b1);
`ifdef PPU_ARB_STARVE_EN
    check_eq("starve_cpu_slots", n_cpu_dut - c0_dut, n_cpu_mdl - c0_mdl);
`else
    check_eq("starve_cpu_slots", n_cpu_dut - c0_dut, 32'd0);
`endif

    // Reset in the data phase of a CPU read.
    ren_req = 1'b0; cpu_req = 1'b0; rendering = 1'b0;
    repeat (4) step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2005;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (cpu_gnt) got = 1'b1;
    end
    check_eq("pre_rst_gnt_seen", {31'd0, got}, 32'd1);
    cpu_req = 1'b0;
    step();
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_ctl", {26'd0, ren_gnt, ren_valid, cpu_gnt, cpu_valid, ale, ppu_wr}, 32'd0);
    check_eq("async_rst_appu", {18'd0, appu}, 32'd0);
    repeat (3) step();
    rst = 1'b0;

    // Fresh CPU read after release: GNT at E+1, VALID at E+3.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2005; ppudi = 8'h5A;
    step();
    check_eq("rd_gnt", {31'd0, cpu_gnt}, 32'd1);
    check_eq("rd_ale", {31'd0, ale}, 32'd1);
    check_eq("rd_appu", {18'd0, appu}, 32'h2005);
    cpu_req = 1'b0;
    step();
    ppudi = 8'hA5;
    check_eq("rd_data_phase_ale", {31'd0, ale}, 32'd0);
    check_eq("rd_no_early_valid", {31'd0, cpu_valid}, 32'd0);
    step();
    ppudi = 8'h3C;
    check_eq("rd_valid", {31'd0, cpu_valid}, 32'd1);
    check_eq("rd_rdata", {24'd0, cpu_rdata}, 32'hA5);

    // CPU write 0x3F00 <= 0x27.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3F00; cpu_wdata = 8'h27;
    step();
    check_eq("wr_gnt", {31'd0, cpu_gnt}, 32'd1);
    cpu_req = 1'b0;
    step();
    check_eq("wr_appu", {18'd0, appu}, 32'h3F00);
    check_eq("wr_ppudo", {24'd0, ppudo}, 32'h27);
    check_eq("wr_strobe", {31'd0, ppu_wr}, 32'd1);
    step();
    check_eq("wr_valid", {31'd0, cpu_valid}, 32'd1);
    check_eq("wr_rdata_kept", {24'd0, cpu_rdata}, 32'hA5);
    check_eq("wr_strobe_off", {31'd0, ppu_wr}, 32'd0);

    repeat (200) drive_cycle(1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
